// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Conditions raw asynchronous push-buttons and slide switches for a
//   processor system. Every raw bit is synchronized with two flops and then
//   debounced by its own STABLE/PENDING state machine. After reset a global
//   INIT phase waits DEBOUNCE_CYCLES cycles and then loads every debounced
//   output straight from its synchronized input, so the power-on switch
//   positions appear without any change strobes.
//
// Ports:
//   clk_clk          in   1      system clock
//   reset_reset_n    in   1      asynchronous active-low reset
//   key_raw_n        in   KEY_W  raw push-buttons, active-low
//   sw_raw           in   SW_W   raw slide switches
//   key_event_clr    in   KEY_W  per-bit clear of key_event_latch
//   port_key_export  out  KEY_W  debounced keys, active-low
//   port_sw_export   out  SW_W   debounced switches
//   key_press_pulse  out  KEY_W  one-cycle strobe per accepted press (1->0)
//   sw_change_pulse  out  SW_W   one-cycle strobe per accepted switch change
//   key_event_latch  out  KEY_W  sticky press flag
//   init_done        out  1      post-reset settle period finished
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int KEY_W           = 2,
  parameter int SW_W            = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [KEY_W-1:0] key_raw_n,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [KEY_W-1:0] key_event_clr,
  output logic [KEY_W-1:0] port_key_export,
  output logic [SW_W-1:0]  port_sw_export,
  output logic [KEY_W-1:0] key_press_pulse,
  output logic [SW_W-1:0]  sw_change_pulse,
  output logic [KEY_W-1:0] key_event_latch,
  output logic             init_done
);

  // Keys occupy the low bits of the combined vector, switches the high bits.
  localparam int N = KEY_W + SW_W;
  // Idle level of each bit: released keys read 1, switches read 0.
  localparam logic [N-1:0] RST_VAL   = {{SW_W{1'b0}}, {KEY_W{1'b1}}};
  localparam logic [19:0]  CNT_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0]  INIT_LAST = 20'(DEBOUNCE_CYCLES);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [N-1:0]       raw_s;
  logic [N-1:0]       sync1_q, sync2_q;
  logic [N-1:0]       deb_q, deb_d;
  logic [N-1:0]       accept_s;
  logic [N-1:0][19:0] cnt_q, cnt_d;
  state_e             state_q [N];
  state_e             state_d [N];
  logic [19:0]        init_cnt_q, init_cnt_d;
  logic               init_done_q, init_done_d;
  logic               load_s;
  logic [KEY_W-1:0]   key_pulse_q, key_pulse_d;
  logic [SW_W-1:0]    sw_pulse_q, sw_pulse_d;
  logic [KEY_W-1:0]   latch_q, latch_d;

  assign raw_s = {sw_raw, key_raw_n};

  // Two-flop synchronizer for every raw input bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // INIT phase: count DEBOUNCE_CYCLES cycles, then load all outputs once.
  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    load_s      = 1'b0;
    if (!init_done_q) begin
      if (init_cnt_q == INIT_LAST) begin
        load_s      = 1'b1;
        init_done_d = 1'b1;
      end else begin
        init_cnt_d = init_cnt_q + 20'd1;
      end
    end else begin
      init_cnt_d = init_cnt_q;
    end
  end

  // Per-bit debounce next-state: each bit needs DEBOUNCE_CYCLES consecutive
  // differing samples, the first of which moves STABLE to PENDING.
  always_comb begin
    deb_d    = deb_q;
    accept_s = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      if (load_s) begin
        deb_d[i]   = sync2_q[i];
        state_d[i] = ST_STABLE;
        cnt_d[i]   = 20'd0;
      end else if (!init_done_q) begin
        state_d[i] = ST_STABLE;
        cnt_d[i]   = 20'd0;
      end else begin
        case (state_q[i])
          ST_STABLE: begin
            if (sync2_q[i] != deb_q[i]) begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = 20'd1;
            end else begin
              cnt_d[i] = 20'd0;
            end
          end
          ST_PENDING: begin
            if (sync2_q[i] == deb_q[i]) begin
              // Input returned before the hold time elapsed: glitch rejected.
              state_d[i] = ST_STABLE;
              cnt_d[i]   = 20'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
              deb_d[i]    = ~deb_q[i];
              accept_s[i] = 1'b1;
              state_d[i]  = ST_STABLE;
              cnt_d[i]    = 20'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 20'd1;
            end
          end
          default: begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = 20'd0;
          end
        endcase
      end
    end
  end

  // Strobes and sticky latch; the latch samples the registered press strobe,
  // so a clear in the strobe cycle loses against the set.
  always_comb begin
    key_pulse_d = accept_s[KEY_W-1:0] & deb_q[KEY_W-1:0];
    sw_pulse_d  = accept_s[N-1:KEY_W];
    latch_d     = key_pulse_q | (latch_q & ~key_event_clr);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_q       <= RST_VAL;
      cnt_q       <= '0;
      init_cnt_q  <= 20'd0;
      init_done_q <= 1'b0;
      key_pulse_q <= '0;
      sw_pulse_q  <= '0;
      latch_q     <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_STABLE;
      end
    end else begin
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      key_pulse_q <= key_pulse_d;
      sw_pulse_q  <= sw_pulse_d;
      latch_q     <= latch_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign port_key_export = deb_q[KEY_W-1:0];
  assign port_sw_export  = deb_q[N-1:KEY_W];
  assign key_press_pulse = key_pulse_q;
  assign sw_change_pulse = sw_pulse_q;
  assign key_event_latch = latch_q;
  assign init_done       = init_done_q;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable cycles required to accept a change (1 ms at 50 MHz); legal range 2..1048575.
REQ-002 SHALL have parameter KEY_W, default 2, giving the number of push-button inputs.
REQ-003 SHALL have parameter SW_W, default 4, giving the number of slide-switch inputs.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port reset_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port key_raw_n, input, KEY_W bits: raw asynchronous push-buttons, active-low.
REQ-007 SHALL have port sw_raw, input, SW_W bits: raw asynchronous switches.
REQ-008 SHALL have port key_event_clr, input, KEY_W bits: per-bit clear for key_event_latch.
REQ-009 SHALL have port port_key_export, output, KEY_W bits: debounced keys, active-low; feeds the processor system's port_key_export input.
REQ-010 SHALL have port port_sw_export, output, SW_W bits: debounced switches; feeds the processor system's port_sw_export input.
REQ-011 SHALL have port key_press_pulse, output, KEY_W bits: one-cycle strobe on each accepted 1->0 key transition.
REQ-012 SHALL have port sw_change_pulse, output, SW_W bits: one-cycle strobe on each accepted switch change, either direction.
REQ-013 SHALL have port key_event_latch, output, KEY_W bits: sticky flag set by key_press_pulse.
REQ-014 SHALL have port init_done, output, 1 bit: high once the post-reset settle period has completed.

Function
REQ-015 SHALL pass every raw input through a two-flop synchronizer before any other logic uses it.
REQ-016 SHALL run a global INIT phase after reset: a counter counts DEBOUNCE_CYCLES cycles, then on the next edge loads every debounced output from its synchronized input, sets init_done=1 and generates no pulses.
REQ-017 SHALL hold all per-bit FSMs idle while init_done=0.
REQ-018 SHALL implement an independent FSM per input bit with states STABLE and PENDING and a 20-bit counter.
REQ-019 In STABLE, when sync != debounced, the FSM SHALL go to PENDING with counter=1.
REQ-020 In PENDING, when sync == debounced, the FSM SHALL return to STABLE with counter=0, leaving the output and pulses unchanged (glitch rejected).
REQ-021 In PENDING, when sync != debounced and counter == DEBOUNCE_CYCLES-1, the FSM SHALL invert the debounced output, assert the bit's pulse on that same edge for exactly one cycle, and return to STABLE with counter=0.
REQ-022 In PENDING otherwise, the FSM SHALL increment the counter.
REQ-023 An accepted change SHALL appear exactly 2 + DEBOUNCE_CYCLES cycles after the raw input settles, provided the change starts while in STABLE.
REQ-024 key_press_pulse SHALL fire only on debounced 1->0 key transitions; a release SHALL produce no pulse.
REQ-025 key_event_latch SHALL be set by key_press_pulse and cleared by key_event_clr; when both occur in the same cycle, set SHALL win.
REQ-026 All outputs SHALL be registered; all bits SHALL operate fully independently, including simultaneous events on several bits.

Reset
REQ-027 Asserting reset_reset_n low at any time, including mid-PENDING or mid-INIT, SHALL asynchronously force: synchronizers key=1 and sw=0, port_key_export all 1, port_sw_export all 0, all pulses 0, key_event_latch 0, init_done 0, all FSMs in STABLE, all counters 0.
REQ-028 After reset release, the module SHALL restart the INIT phase from count 0.

Verification (DEBOUNCE_CYCLES=8)
REQ-029 Reset release with sw_raw=4'b1010 held: init_done rises, port_sw_export becomes 1010, and no sw_change_pulse ever fires.
REQ-030 key_raw_n[0] driven 1->0 and held: port_key_export[0]=0 and key_press_pulse[0] high for one cycle exactly 10 cycles later; key_event_latch[0]=1 afterwards.
REQ-031 key_raw_n[1] low for 5 cycles, then high: no output change and no pulse.
REQ-032 sw_raw[2] toggled every 4 cycles for 100 cycles, then held at 1: exactly one sw_change_pulse[2], occurring 10 cycles after the final edge.
REQ-033 key_event_clr[0] asserted in the same cycle as key_press_pulse[0]: latch stays 1; a clear on the next cycle sets it to 0.
REQ-034 reset_reset_n pulsed low while sw_raw[0] is PENDING at count 5: all outputs go to their reset values immediately and no pulse is emitted.
